// File: rtl/shake_block_assembler.sv
// shake_block_assembler
// Packs a stream of 64-bit message words (MSB-first) into 1088-bit SHAKE256
// rate blocks for the downstream pad stage.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input word handshake
//   in_data              message word, first message bit at in_data[W-1]
//   in_last              final message word
//   in_bits              valid MSB-aligned bits in the final word (0..64, >64 clamps)
//   out_valid/out_ready  output block handshake
//   out_block            packed block, word k at [RATE-1-W*k -: W]
//   out_length           valid message bits in out_block, counted from the MSB
//   out_last             final block of the message
module shake_block_assembler #(
  parameter int unsigned RATE  = 1088,
  parameter int unsigned W     = 64,
  parameter int unsigned WORDS = 17,
  parameter int unsigned LW    = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  input  logic [6:0]      in_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RATE-1:0] out_block,
  output logic [LW-1:0]   out_length,
  output logic            out_last
);

  localparam int unsigned CntW = $clog2(WORDS);

  typedef enum logic [1:0] {StFill, StEmit, StEmitExtra} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RATE-1:0]   block_q, block_d;
  logic [LW-1:0]     len_q, len_d;
  logic              last_q, last_d;

  logic [6:0]        bits_c;
  logic [W-1:0]      mask_c;
  logic [W-1:0]      word_c;
  logic [LW-1:0]     len_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    len_d   = len_q;
    last_d  = last_q;

    bits_c = (in_bits > 7'(W)) ? 7'(W) : in_bits;
    // Keep the top bits_c bits of the final word, zero the rest.
    mask_c = (bits_c >= 7'(W)) ? '1 : ~({W{1'b1}} >> bits_c);
    word_c = in_last ? (in_data & mask_c) : in_data;
    len_c  = LW'(cnt_q) * LW'(W) + LW'(bits_c);

    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < WORDS; k++) begin
            if (cnt_q == CntW'(k)) block_d[RATE-1-W*k -: W] = word_c;
          end
          cnt_d = cnt_q + 1'b1;
          if (in_last) begin
            if (len_c == LW'(RATE)) begin
              // Exactly full final block: pad needs a separate empty last block.
              state_d = StEmitExtra;
              len_d   = LW'(RATE);
              last_d  = 1'b0;
            end else begin
              state_d = StEmit;
              len_d   = len_c;
              last_d  = 1'b1;
            end
          end else if (cnt_q == CntW'(WORDS - 1)) begin
            state_d = StEmit;
            len_d   = LW'(RATE);
            last_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          state_d = StFill;
          block_d = '0;
          cnt_d   = '0;
          len_d   = '0;
          last_d  = 1'b0;
        end
      end
      StEmitExtra: begin
        if (out_ready) begin
          state_d = StEmit;
          block_d = '0;
          len_d   = '0;
          last_d  = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      cnt_q   <= '0;
      block_q <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      len_q   <= len_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == StFill);
  assign out_valid  = (state_q != StFill);
  assign out_block  = block_q;
  assign out_length = len_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_shake_block_assembler.sv
// Scoreboard bench for shake_block_assembler: a bit-level message model
// predicts every block; a monitor compares on each output handshake.
module tb_shake_block_assembler;

  localparam int RATE = 1088;
  localparam int W    = 64;
  localparam int LW   = 11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic [6:0]      in_bits;
  logic            out_valid;
  logic            out_ready;
  logic [RATE-1:0] out_block;
  logic [LW-1:0]   out_length;
  logic            out_last;

  shake_block_assembler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bits    (in_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .out_length (out_length),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RATE-1:0] blk;
    int              len;
    logic            last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] msg_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic chk_block(input string name, input logic [RATE-1:0] got,
                           input logic [RATE-1:0] want);
    bit shown;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      shown = 1'b0;
      for (int k = 0; k < RATE / W; k++) begin
        if (!shown && got[RATE-1-W*k -: W] !== want[RATE-1-W*k -: W]) begin
          $display("FAIL %s slot %0d: got %h, expected %h", name, k,
                   got[RATE-1-W*k -: W], want[RATE-1-W*k -: W]);
          shown = 1'b1;
        end
      end
    end
  endtask

  // Model: message is a bitstream of T bits; block b holds bits [RATE*b, RATE*b+RATE).
  // There are always floor(T/RATE)+1 blocks, so exact multiples end with an empty block.
  task automatic push_expected(input int bits);
    int   eff, total, nb, len, j;
    exp_t e;
    eff   = (bits > 64) ? 64 : bits;
    total = 64 * (msg_q.size() - 1) + eff;
    nb    = total / RATE + 1;
    for (int b = 0; b < nb; b++) begin
      len = total - RATE * b;
      if (len > RATE) len = RATE;
      e.blk = '0;
      for (int i = 0; i < len; i++) begin
        j = RATE * b + i;
        e.blk[RATE-1-i] = msg_q[j / 64][63 - (j % 64)];
      end
      e.len  = len;
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input int bits);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bits  = 7'(bits);
    t = 0;
    while (!in_ready && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = $urandom_range(0, 1);
    in_bits  = 7'($urandom_range(0, 127));
    in_data  = {$urandom, $urandom};
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  // rnd=0 fills every word with pat
  task automatic build_msg(input int n, input bit rnd, input logic [63:0] pat);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(rnd ? {$urandom, $urandom} : pat);
  endtask

  task automatic send_msg(input int n, input int bits, input bit rnd, input logic [63:0] pat);
    build_msg(n, rnd, pat);
    push_expected(bits);
    for (int i = 0; i < n; i++) send_word(msg_q[i], (i == n - 1), bits);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a block transfers at the next rising edge when valid and ready are high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_block: got length %0d last %0b, expected no block",
                   out_length, out_last);
        end else begin
          e = exp_q.pop_front();
          chk("out_length", 64'(out_length), 64'(e.len));
          chk("out_last", 64'(out_last), 64'(e.last));
          chk_block("out_block", out_block, e.blk);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    logic [RATE-1:0] hold_blk;
    logic [LW-1:0]   hold_len;
    logic            hold_last;
    int              t;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bits  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_length", 64'(out_length), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk_block("reset_out_block", out_block, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    send_msg(1, 3, 1'b0, 64'hA000_0000_0000_0000);
    send_msg(17, 63, 1'b0, 64'h0101_0101_0101_0101);
    send_msg(17, 64, 1'b1, '0);
    send_msg(20, 64, 1'b1, '0);
    send_msg(1, 0, 1'b1, '0);
    send_msg(5, 100, 1'b1, '0);
    drain("drain_directed");

    // Backpressure: outputs frozen, extra input words refused
    rdy_mode = 1;
    @(posedge clk); #1;
    send_msg(1, 10, 1'b1, '0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    hold_blk  = out_block;
    hold_len  = out_length;
    hold_last = out_last;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_bits  = 7'd5;
      in_data  = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_length", 64'(out_length), 64'(hold_len));
      chk("stall_last", 64'(out_last), 64'(hold_last));
      chk_block("stall_block", out_block, hold_blk);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    drain("drain_stall");
    repeat (3) @(posedge clk);
    #1;
    chk("post_stall_idle", 64'(out_valid), 64'd0);

    // Reset mid-message discards the partial block
    build_msg(9, 1'b1, '0);
    for (int i = 0; i < 9; i++) send_word(msg_q[i], 1'b0, 64);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_length", 64'(out_length), 64'd0);
    send_msg(1, 17, 1'b1, '0);
    drain("drain_reset");

    // Randomized messages with random backpressure
    rdy_mode = 0;
    for (int m = 0; m < 25; m++) begin
      int n, b;
      n = $urandom_range(1, 40);
      b = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 64);
      send_msg(n, b, 1'b1, '0);
    end
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
